image_correction: RTL and testbench



---
 rtl/image_correction.sv | 192 +++++++++++++++++++
 tb/tb_image_correction.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_correction.sv
// image_correction
//   Collects one square frame of single-channel pixels in raster order and
//   halves it on both axes. Each output pixel is the rounded mean of a 2x2
//   input block. The result goes into an on-chip frame memory, and the frame
//   is then streamed out on demand.
//
//   The block alternates between two phases:
//     WRITE - pixels are accepted (frameReady = 0)
//     READ  - the buffered frame is read out (frameReady = 1)
//
// Parameters
//   DATA_WIDTH : pixel width in bits
//   IN_RES     : input frame width and height (square, even)
//   OUT_RES    : output frame width and height (IN_RES / 2)
//
// Ports
//   clk0       : single clock, rising edge
//   rst        : asynchronous reset, active low
//   dIn        : input pixel, raster order
//   dInValid   : dIn carries a pixel this cycle (ignored while in READ)
//   dOuten     : level-sensitive read request (ignored while in WRITE)
//   dOut       : registered output pixel; holds while dOutValid is low
//   dOutValid  : dOut carries a pixel this cycle
//   frameReady : a complete output frame is buffered and not yet fully read
module image_correction #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_RES     = 346,
  parameter int OUT_RES    = IN_RES / 2
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dIn,
  input  logic                  dInValid,
  input  logic                  dOuten,
  output logic [DATA_WIDTH-1:0] dOut,
  output logic                  dOutValid,
  output logic                  frameReady
);

  localparam int CNT_W   = (IN_RES > 1) ? $clog2(IN_RES) : 1;
  localparam int OX_W    = (OUT_RES > 1) ? $clog2(OUT_RES) : 1;
  localparam int PIX_CNT = OUT_RES * OUT_RES;
  localparam int ADDR_W  = (PIX_CNT > 1) ? $clog2(PIX_CNT) : 1;

  localparam logic [CNT_W-1:0]  LAST_COORD = CNT_W'(IN_RES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PIX_CNT - 1);

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } phaseT;

  phaseT state;
  phaseT nextState;

  logic [CNT_W-1:0]      xCnt;
  logic [CNT_W-1:0]      yCnt;
  logic [ADDR_W-1:0]     wrAddr;
  logic [ADDR_W-1:0]     rdPtr;
  logic [DATA_WIDTH-1:0] firstPix;
  logic [OX_W-1:0]       ox;

  logic [DATA_WIDTH:0]   lineBuf  [OUT_RES];
  logic [DATA_WIDTH-1:0] frameMem [PIX_CNT];

  logic                  accept;
  logic                  lastPix;
  logic                  lineWe;
  logic                  memWe;
  logic                  issue;
  logic                  lastRd;
  logic [DATA_WIDTH:0]   pairSum;
  logic [DATA_WIDTH+1:0] blockSum;
  logic [DATA_WIDTH-1:0] avg;

  // Handshake decode. A pixel is taken only in WRITE and a read only in READ.
  // That gating alone makes the block ignore dInValid while reading and
  // ignore dOuten while writing.
  assign accept  = (state == WRITE) && dInValid;
  assign lastPix = accept && (xCnt == LAST_COORD) && (yCnt == LAST_COORD);
  assign issue   = (state == READ) && dOuten;
  assign lastRd  = issue && (rdPtr == LAST_ADDR);

  // Datapath for the 2x2 mean.
  // An even column only latches its pixel. The odd column completes the
  // horizontal pair. Even rows park that pair in the line buffer. Odd rows
  // fetch the parked pair, add the rounding constant and drop two bits.
  // The sum is kept two bits wider than a pixel, so four full-scale pixels
  // plus the rounding constant cannot overflow.
  assign ox       = OX_W'(xCnt >> 1);
  assign pairSum  = {1'b0, firstPix} + {1'b0, dIn};
  assign blockSum = {1'b0, lineBuf[ox]} + {1'b0, pairSum} + (DATA_WIDTH + 2)'(2);
  assign avg      = DATA_WIDTH'(blockSum >> 2);
  assign lineWe   = accept && xCnt[0] && !yCnt[0];
  assign memWe    = accept && xCnt[0] && yCnt[0];

  assign frameReady = (state == READ);

  // Phase register. Reset returns to WRITE, which discards any partial
  // frame or partial readout.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      state <= WRITE;
    end else begin
      state <= nextState;
    end
  end

  // Phase transitions.
  // The last input pixel hands the frame over to the reader. Issuing the
  // last read address hands control back to the writer. The data for that
  // last address still leaves the block one cycle later.
  always_comb begin
    nextState = state;
    unique case (state)
      WRITE: if (lastPix) nextState = READ;
      READ:  if (lastRd)  nextState = WRITE;
      default: nextState = WRITE;
    endcase
  end

  // Input-side counters.
  // x advances on every accepted pixel and wraps into y. Everything is
  // cleared when the final pixel of the frame is taken. wrAddr simply counts
  // completed blocks. Blocks finish in raster order, so wrAddr always equals
  // oy*OUT_RES+ox without needing a multiplier.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      xCnt     <= '0;
      yCnt     <= '0;
      wrAddr   <= '0;
      firstPix <= '0;
    end else begin
      if (accept) begin
        if (!xCnt[0]) begin
          firstPix <= dIn;
        end
        if (lastPix) begin
          xCnt <= '0;
          yCnt <= '0;
        end else if (xCnt == LAST_COORD) begin
          xCnt <= '0;
          yCnt <= yCnt + 1'b1;
        end else begin
          xCnt <= xCnt + 1'b1;
        end
      end
      if (lastPix) begin
        wrAddr <= '0;
      end else if (memWe) begin
        wrAddr <= wrAddr + 1'b1;
      end
    end
  end

  // Storage arrays.
  // These have no reset, which lets them map onto RAM. Their contents are
  // always rewritten before being read, so stale data after a reset is
  // harmless.
  always_ff @(posedge clk0) begin
    if (lineWe) begin
      lineBuf[ox] <= pairSum;
    end
    if (memWe) begin
      frameMem[wrAddr] <= avg;
    end
  end

  // Readout.
  // Each cycle with dOuten issues one address. The memory word is registered
  // straight into dOut, so data follows the request by exactly one cycle.
  // dOut is left untouched on idle cycles so that it holds its last value.
  // The pointer wraps to 0 after the final address.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      rdPtr     <= '0;
      dOut      <= '0;
      dOutValid <= 1'b0;
    end else begin
      dOutValid <= issue;
      if (issue) begin
        dOut <= frameMem[rdPtr];
      end
      if (lastRd) begin
        rdPtr <= '0;
      end else if (issue) begin
        rdPtr <= rdPtr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_correction.sv
// tb_image_correction
//   Scoreboard bench for image_correction. It uses a reduced 8x8 -> 4x4
//   frame so that every scenario completes in a few hundred cycles.
//
//   The stimulus process loads directed frames, each with hand-computed
//   block means. When a frame is complete, it queues the expected outputs
//   and tracks when frameReady should be high. A negedge monitor checks
//   frameReady and dOutValid every cycle, pops the queue on each valid
//   output, and checks that dOut holds between outputs.
module tb_image_correction;

  localparam int DW   = 8;
  localparam int IR   = 8;
  localparam int OR   = 4;
  localparam int NPIX = IR * IR;
  localparam int NOUT = OR * OR;

  logic          clk0 = 1'b0;
  logic          rst;
  logic [DW-1:0] dIn;
  logic          dInValid;
  logic          dOuten;
  logic [DW-1:0] dOut;
  logic          dOutValid;
  logic          frameReady;

  int compared   = 0;
  int mismatched = 0;

  int expQ[$];
  bit expReady     = 1'b0;
  bit done         = 1'b0;
  bit pendingValid = 1'b0;
  int lastExp      = 0;

  int pix  [NPIX];
  int expV [NOUT];

  // Rounding blocks, given as p(2ox,2oy), p(2ox+1,2oy), p(2ox,2oy+1),
  // p(2ox+1,2oy+1), together with each block's hand-computed rounded mean.
  int tA  [12] = '{1, 1, 255, 0, 0, 0, 10, 254, 3, 0,   7, 200};
  int tB  [12] = '{1, 2, 255, 0, 0, 0, 20, 255, 3, 255, 8, 201};
  int tC  [12] = '{1, 2, 255, 0, 0, 0, 30, 255, 3, 255, 9, 202};
  int tD  [12] = '{2, 2, 255, 3, 1, 2, 40, 255, 3, 0,   9, 203};
  int tExp[12] = '{1, 2, 255, 1, 0, 1, 25, 255, 3, 128, 8, 202};

  image_correction #(
    .DATA_WIDTH(DW),
    .IN_RES    (IR),
    .OUT_RES   (OR)
  ) dut (
    .clk0      (clk0),
    .rst       (rst),
    .dIn       (dIn),
    .dInValid  (dInValid),
    .dOuten    (dOuten),
    .dOut      (dOut),
    .dOutValid (dOutValid),
    .frameReady(frameReady)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk0 = ~clk0;

  // Single comparison point. Every check in the bench goes through here.
  task automatic checkOutput(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, req, $time);
    end
  endtask

  // Advance to just after the next rising edge. Inputs change here, well
  // clear of both clock edges.
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  // Drive one input-side cycle.
  task automatic applyStimulus(input bit valid, input int data);
    dInValid = valid;
    dIn      = data[DW-1:0];
    tick();
  endtask

  // Build a frame and its expected outputs.
  //   kind 0 : constant val
  //   kind 1 : pixel-alternating 0/255 checkerboard
  //   kind 2 : rounding table
  // Then feed pixels, randomly idling dInValid for roughly gapPct percent of
  // cycles. If stopAfter is below a full frame, the load is left unfinished.
  task automatic loadFrame(input int kind, input int val, input int gapPct,
                           input bit enDuringLoad, input int stopAfter);
    int i;
    int guard;
    int t;
    for (int oy = 0; oy < OR; oy++) begin
      for (int ox = 0; ox < OR; ox++) begin
        t = (oy * OR + ox) % 12;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            case (kind)
              0: pix[(2*oy+dy)*IR + 2*ox+dx] = val;
              1: pix[(2*oy+dy)*IR + 2*ox+dx] = ((dx + dy) % 2 == 1) ? 255 : 0;
              default: begin
                if (dy == 0 && dx == 0) pix[(2*oy)*IR + 2*ox]       = tA[t];
                if (dy == 0 && dx == 1) pix[(2*oy)*IR + 2*ox+1]     = tB[t];
                if (dy == 1 && dx == 0) pix[(2*oy+1)*IR + 2*ox]     = tC[t];
                if (dy == 1 && dx == 1) pix[(2*oy+1)*IR + 2*ox+1]   = tD[t];
              end
            endcase
          end
        end
        case (kind)
          0: expV[oy*OR+ox] = val;
          1: expV[oy*OR+ox] = 128;
          default: expV[oy*OR+ox] = tExp[t];
        endcase
      end
    end
    i      = 0;
    guard  = 0;
    dOuten = enDuringLoad;
    while (i < stopAfter && guard < 4000) begin
      guard++;
      if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
        applyStimulus(1'b0, int'($urandom_range(0, 255)));
      end else begin
        applyStimulus(1'b1, pix[i]);
        i++;
      end
    end
    dInValid = 1'b0;
    dOuten   = 1'b0;
    if (stopAfter == NPIX) begin
      expReady = 1'b1;
      for (int k = 0; k < NOUT; k++) expQ.push_back(expV[k]);
    end
  endtask

  // Request count outputs.
  // With randomEn set, dOuten is toggled randomly. With junk set, garbage
  // pixels are presented during the readout; the DUT must ignore them.
  task automatic readFrame(input bit randomEn, input bit junk, input int count);
    int cnt;
    int guard;
    bit en;
    cnt   = 0;
    guard = 0;
    while (cnt < count && guard < 2000) begin
      guard++;
      en     = randomEn ? bit'($urandom_range(0, 1)) : 1'b1;
      dOuten = en;
      if (junk) begin
        dInValid = 1'b1;
        dIn      = DW'($urandom_range(0, 255));
      end
      tick();
      if (en) cnt++;
    end
    dOuten   = 1'b0;
    dInValid = 1'b0;
    if (count == NOUT) expReady = 1'b0;
    tick();
    tick();
  endtask

  // Pulse the asynchronous reset. Anything still queued belongs to the
  // frame being discarded.
  task automatic resetPulse();
    rst      = 1'b0;
    expQ.delete();
    expReady = 1'b0;
    dOuten   = 1'b0;
    dInValid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Monitor.
  // During reset, all outputs must be zero. Otherwise it checks:
  //   - frameReady against the stimulus-side expectation;
  //   - dOutValid against the request seen one cycle earlier;
  //   - each valid pixel against the scoreboard;
  //   - dOut holding its last expected value while idle.
  always @(negedge clk0) begin
    if (!rst) begin
      checkOutput("resetDOut", int'(dOut), 0);
      checkOutput("resetDOutValid", int'(dOutValid), 0);
      checkOutput("resetFrameReady", int'(frameReady), 0);
      pendingValid = 1'b0;
      lastExp      = 0;
    end else begin
      checkOutput("frameReady", int'(frameReady), int'(expReady));
      checkOutput("dOutValid", int'(dOutValid), int'(pendingValid));
      if (dOutValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOutput", int'(dOutValid), 0);
        end else begin
          lastExp = expQ.pop_front();
          checkOutput("dOut", int'(dOut), lastExp);
        end
      end else begin
        checkOutput("dOutHold", int'(dOut), lastExp);
      end
      pendingValid = expReady && dOuten;
    end
    if (done) begin
      checkOutput("outputsRemaining", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  // Directed scenarios in order.
  //   1. Constant frame, read straight through.
  //   2. Checkerboard with input gaps, dOuten held high during the load.
  //   3. Rounding blocks, read with random dOuten while junk pixels are
  //      presented.
  //   4. Reset mid-load and mid-readout, each followed by a clean frame.
  initial begin
    rst      = 1'b0;
    dIn      = '0;
    dInValid = 1'b0;
    dOuten   = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    $display("[TB] constant 100 frame");
    loadFrame(0, 100, 0, 1'b0, NPIX);
    readFrame(1'b0, 1'b0, NOUT);

    $display("[TB] checkerboard with input gaps");
    loadFrame(1, 0, 30, 1'b1, NPIX);
    readFrame(1'b0, 1'b0, NOUT);

    $display("[TB] rounding blocks, random dOuten, junk input");
    loadFrame(2, 0, 0, 1'b0, NPIX);
    readFrame(1'b1, 1'b1, NOUT);

    $display("[TB] reset mid-write");
    loadFrame(0, 77, 0, 1'b0, 30);
    resetPulse();
    loadFrame(2, 0, 30, 1'b0, NPIX);

    $display("[TB] reset mid-read, then constant 50 frame");
    readFrame(1'b0, 1'b0, 5);
    resetPulse();
    loadFrame(0, 50, 30, 1'b0, NPIX);
    readFrame(1'b1, 1'b0, NOUT);

    repeat (3) tick();
    done = 1'b1;
  end

endmodule
